// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes
// and the datapath select/ALU encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU control decode: ALUOp plus funct fields to a 3-bit ALU operation.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       op_5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op[5]=1) can encode sub; addi ignores instr[30].
          3'b000:  alu_control = (op_5 & funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM with memory-ready stalls.
// Optional retired-instruction counter enabled by defining MC_INSTRET_EN.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       illegal_op,
  output state_t     state
`ifdef MC_INSTRET_EN
  ,
  output logic [INSTRET_W-1:0] instret
`endif
);

  state_t     state_next;
  logic [1:0] alu_op;
  logic       pc_update, branch;
  logic       mem_write_s, ir_write_s, reg_write_s, illegal_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = S_FETCH;
    alu_op      = ALUOP_ADD;
    pc_update   = 1'b0;
    branch      = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    illegal_s   = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RD2;
    case (state)
      S_FETCH: begin
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        ir_write_s = mem_ready;
        pc_update  = mem_ready;
        state_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
          default: begin
            state_next = S_FETCH;
            illegal_s  = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMM;
        state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc     = 1'b1;
        state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
        state_next  = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        ALUSrcA    = SRCA_RD1;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA    = SRCA_RD1;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: reg_write_s = 1'b1;
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Enables are masked by rst_n so nothing strobes while reset is held.
  assign PCWrite    = rst_n & ((branch & Zero) | pc_update);
  assign MemWrite   = rst_n & mem_write_s;
  assign IRWrite    = rst_n & ir_write_s;
  assign RegWrite   = rst_n & reg_write_s;
  assign illegal_op = rst_n & illegal_s;

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  mc_alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .op_5        (op[5]),
    .alu_control (ALUControl)
  );

`ifdef MC_INSTRET_EN
  logic retire;
  assign retire = (state_next == S_FETCH) &&
                  ((state == S_MEMWB) || (state == S_ALUWB) ||
                   (state == S_BEQ) || (state == S_MEMWRITE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret <= '0;
    else if (retire) instret <= instret + 1'b1;
  end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected output traces built
// from the instruction-level rules, with random stalls and random instructions.
module tb_multicycle_controller;
  import mc_pkg::*;

  localparam int INSTRET_W = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = OP_SW;
  logic [2:0] funct3 = 3'b000;
  logic       funct7_5 = 1'b0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  state_t     dbg_state;
`ifdef MC_INSTRET_EN
  logic [INSTRET_W-1:0] instret;
`endif

  multicycle_controller #(.INSTRET_W(INSTRET_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .illegal_op (illegal_op),
    .state      (dbg_state)
`ifdef MC_INSTRET_EN
    ,
    .instret    (instret)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // observed output vector: PCW AdrSrc MemW IRW RegW Res[2] A[2] B[2] ALU[3] Imm[3] ill
  logic [17:0] obs;
  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal_op};

  // scoreboard
  logic [17:0] exp_q[$];
  logic [17:0] mask_q[$];
  bit          rdy_q[$];
  logic [INSTRET_W-1:0] exp_instret = '0;
  int    n_checks = 0;
  int    n_errors = 0;
  string cur_tag = "reset";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] ov(input bit pcw, input bit adr, input bit mw,
                                     input bit irw, input bit rw, input logic [1:0] res,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [2:0] alu, input logic [2:0] imm,
                                     input bit ill);
    return {pcw, adr, mw, irw, rw, res, a, b, alu, imm, ill};
  endfunction

  // care mask; enables, ImmSrc and illegal_op are always checked
  function automatic logic [17:0] mk(input bit c_adr, input bit c_res, input bit c_a,
                                     input bit c_b, input bit c_alu);
    return {1'b1, c_adr, 3'b111, {2{c_res}}, {2{c_a}}, {2{c_b}}, {3{c_alu}}, 3'b111, 1'b1};
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 3'b001;
    if (o == 7'b1100011) return 3'b010;
    if (o == 7'b1101111) return 3'b011;
    return 3'b000;
  endfunction

  // arithmetic operation selected by the funct fields for R/I instructions
  function automatic logic [2:0] funct_alu(input logic [2:0] f3, input bit is_r, input bit f7);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
           o == 7'b0010011 || o == 7'b1101111 || o == 7'b1100011;
  endfunction

  task automatic push(input logic [17:0] e, input logic [17:0] m, input bit r);
    exp_q.push_back(e);
    mask_q.push_back(m);
    rdy_q.push_back(r);
  endtask

  // expected per-cycle trace of one instruction; fst/mst = ready-low cycles
  task automatic build(input logic [6:0] o, input logic [2:0] f3, input bit f7,
                       input bit z, input int fst, input int mst);
    logic [2:0] imm;
    bit         r;
    imm = imm_of(o);
    for (int k = 0; k <= fst; k++) begin
      r = (k == fst);
      push(ov(r, 0, 0, r, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0), mk(1, 1, 1, 1, 1), r);
    end
    push(ov(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, !is_legal(o)),
         mk(0, 0, 1, 1, 1), bit'($urandom_range(0, 1)));
    if (o == 7'b0000011 || o == 7'b0100011) begin
      push(ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, imm, 0), mk(0, 0, 1, 1, 1),
           bit'($urandom_range(0, 1)));
      for (int k = 0; k <= mst; k++) begin
        r = (k == mst);
        push(ov(0, 1, o[5], 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0), mk(1, 1, 0, 0, 0), r);
      end
      if (o == 7'b0000011)
        push(ov(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, imm, 0), mk(0, 1, 0, 0, 0),
             bit'($urandom_range(0, 1)));
    end else if (o == 7'b0110011 || o == 7'b0010011) begin
      push(ov(0, 0, 0, 0, 0, 2'b00, 2'b10, (o[5] ? 2'b00 : 2'b01), funct_alu(f3, o[5], f7), imm, 0),
           mk(0, 0, 1, 1, 1), bit'($urandom_range(0, 1)));
      push(ov(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0), mk(0, 1, 0, 0, 0),
           bit'($urandom_range(0, 1)));
    end else if (o == 7'b1101111) begin
      push(ov(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, imm, 0), mk(0, 1, 1, 1, 1),
           bit'($urandom_range(0, 1)));
      push(ov(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0), mk(0, 1, 0, 0, 0),
           bit'($urandom_range(0, 1)));
    end else if (o == 7'b1100011) begin
      push(ov(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, imm, 0), mk(0, 1, 1, 1, 1),
           bit'($urandom_range(0, 1)));
    end
    if (is_legal(o)) exp_instret = exp_instret + 1'b1;
  endtask

  // driver: one queue entry per clock; n<0 drains the queue
  task automatic drive(input int n);
    logic [17:0] e, m;
    bit          r;
    int          done;
    done = 0;
    while (exp_q.size() > 0 && (n < 0 || done < n)) begin
      e = exp_q.pop_front();
      m = mask_q.pop_front();
      r = rdy_q.pop_front();
      @(negedge clk);
      mem_ready = r;
      #1;
      check(cur_tag, {14'b0, obs & m}, {14'b0, e & m});
      done++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input bit f7, input bit z, input int fst, input int mst);
    cur_tag  = tag;
    op       = o;
    funct3   = f3;
    funct7_5 = f7;
    Zero     = z;
    build(o, f3, f7, z, fst, mst);
    drive(-1);
`ifdef MC_INSTRET_EN
    check({tag, "_instret"}, instret, exp_instret);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [17:0] e;
    e = ov(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, imm_of(op), 0);
    mem_ready = 1'b1;
    #1;
    check(tag, {14'b0, obs}, {14'b0, e});
`ifdef MC_INSTRET_EN
    check({tag, "_instret"}, instret, '0);
`endif
  endtask

  initial begin
    logic [6:0] rop;
    logic [6:0] legal_ops[6];
    legal_ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};

    // reset held: enables low even with mem_ready high
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    exp_instret = '0;

    run_instr("add",   OP_R, 3'b000, 0, 0, 0, 0);
    run_instr("sub",   OP_R, 3'b000, 1, 0, 0, 0);
    run_instr("addi",  OP_I, 3'b000, 1, 0, 0, 0);
    run_instr("slt",   OP_R, 3'b010, 0, 0, 0, 0);
    run_instr("or",    OP_R, 3'b110, 0, 0, 0, 0);
    run_instr("andi",  OP_I, 3'b111, 0, 0, 0, 0);
    run_instr("xor",   OP_R, 3'b100, 1, 0, 0, 0);
    run_instr("lw_st", OP_LW, 3'b010, 0, 0, 0, 3);
    run_instr("sw",    OP_SW, 3'b010, 0, 0, 0, 0);
    run_instr("beq_t", OP_BEQ, 3'b000, 0, 1, 0, 0);
    run_instr("beq_n", OP_BEQ, 3'b000, 0, 0, 0, 0);
    run_instr("jal",   OP_JAL, 3'b000, 0, 0, 0, 0);
    run_instr("ill0",  7'b0000000, 3'b000, 0, 0, 0, 0);
    run_instr("fst",   OP_R, 3'b000, 0, 0, 2, 0);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        do rop = 7'($urandom); while (is_legal(rop));
      end else begin
        rop = legal_ops[$urandom_range(0, 5)];
      end
      run_instr("rand", rop, 3'($urandom), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // abort a stalled store with reset
    cur_tag  = "sw_abort";
    op       = OP_SW;
    funct3   = 3'b010;
    funct7_5 = 1'b0;
    build(OP_SW, 3'b010, 0, 0, 0, 5);
    drive(4);
    @(negedge clk);
    mem_ready = 1'b0;
    check("sw_hold", {31'b0, MemWrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_memwrite", {31'b0, MemWrite}, 32'd0);
    check_reset_outputs("rst_mid");
    exp_q.delete();
    mask_q.delete();
    rdy_q.delete();
    exp_instret = '0;
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    run_instr("post_rst", OP_R, 3'b000, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
